// File: rtl/dmem_arbiter.sv
// Two-master (core / secondary) round-robin arbiter in front of a fixed-latency data memory.
// Optional DMEM_ARBITER_BURST_LOCK_EN adds d_lock so the secondary master can keep winning ties.
module dmem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_req,
    input  logic [15:0] c_address,
    input  logic [7:0]  c_o_data,
    input  logic        c_we,
    output logic [7:0]  c_i_data,
    output logic        c_ready,
    input  logic        d_req,
    input  logic [15:0] d_address,
    input  logic [7:0]  d_o_data,
    input  logic        d_we,
    output logic [7:0]  d_i_data,
    output logic        d_ready,
`ifdef DMEM_ARBITER_BURST_LOCK_EN
    input  logic        d_lock,
`endif
    output logic [15:0] m_address,
    output logic [7:0]  m_o_data,
    output logic        m_we,
    input  logic [7:0]  m_i_data
);

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last;     // last granted master: 0 core, 1 secondary
    logic       gnt;      // master owning the current access
    logic       wr;       // current access is a write
    logic       grant, sel, done, burst;

`ifdef DMEM_ARBITER_BURST_LOCK_EN
    assign burst = d_lock;
`else
    assign burst = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        sel       = gnt;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    if (c_req && d_req)
                        sel = (last && burst) ? 1'b1 : ~last;
                    else
                        sel = d_req;
                end
            end
            ACCESS: begin
                if (cnt == 4'd1) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            wr        <= 1'b0;
            m_address <= 16'h0000;
            m_o_data  <= 8'h00;
            m_we      <= 1'b0;
            c_i_data  <= 8'h00;
            d_i_data  <= 8'h00;
            c_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            // write strobe and ready are single-cycle pulses
            m_we    <= 1'b0;
            c_ready <= 1'b0;
            d_ready <= 1'b0;
            if (grant) begin
                gnt       <= sel;
                cnt       <= LAT4;
                wr        <= sel ? d_we : c_we;
                m_address <= sel ? d_address : c_address;
                m_o_data  <= sel ? d_o_data : c_o_data;
                m_we      <= sel ? d_we : c_we;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                last <= gnt;
                if (gnt) d_ready <= 1'b1;
                else     c_ready <= 1'b1;
                if (!wr) begin
                    if (gnt) d_i_data <= m_i_data;
                    else     c_i_data <= m_i_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance 0 at LATENCY=1, instance 1 at LATENCY=3.
// Expected grants/readies are queued when stimulus is driven and checked when the DUT responds.
module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        c_req[2], c_we[2], d_req[2], d_we[2], d_lock[2];
    logic [15:0] c_address[2], d_address[2], m_address[2];
    logic [7:0]  c_o_data[2], d_o_data[2], c_i_data[2], d_i_data[2];
    logic [7:0]  m_o_data[2], m_i_data[2];
    logic        c_ready[2], d_ready[2], m_we[2];

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return (a == 16'h0100) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    assign m_i_data[0] = mem_val(m_address[0]);
    assign m_i_data[1] = mem_val(m_address[1]);

    dmem_arbiter #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .c_req(c_req[0]), .c_address(c_address[0]), .c_o_data(c_o_data[0]), .c_we(c_we[0]),
        .c_i_data(c_i_data[0]), .c_ready(c_ready[0]),
        .d_req(d_req[0]), .d_address(d_address[0]), .d_o_data(d_o_data[0]), .d_we(d_we[0]),
        .d_i_data(d_i_data[0]), .d_ready(d_ready[0]),
`ifdef DMEM_ARBITER_BURST_LOCK_EN
        .d_lock(d_lock[0]),
`endif
        .m_address(m_address[0]), .m_o_data(m_o_data[0]), .m_we(m_we[0]), .m_i_data(m_i_data[0])
    );

    dmem_arbiter #(.LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .c_req(c_req[1]), .c_address(c_address[1]), .c_o_data(c_o_data[1]), .c_we(c_we[1]),
        .c_i_data(c_i_data[1]), .c_ready(c_ready[1]),
        .d_req(d_req[1]), .d_address(d_address[1]), .d_o_data(d_o_data[1]), .d_we(d_we[1]),
        .d_i_data(d_i_data[1]), .d_ready(d_ready[1]),
`ifdef DMEM_ARBITER_BURST_LOCK_EN
        .d_lock(d_lock[1]),
`endif
        .m_address(m_address[1]), .m_o_data(m_o_data[1]), .m_we(m_we[1]), .m_i_data(m_i_data[1])
    );

    typedef struct { int inst; int master; logic [7:0] data; int cyc; } rdy_t;
    typedef struct { int inst; logic [15:0] addr; logic we; logic [7:0] wdata; int cyc; } acc_t;

    rdy_t       sbq[$];
    acc_t       aq[$];
    logic [7:0] shadow[2][2];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    // e = edge that grants the access; ready is seen at the negedge with cyc == e + LATENCY
    task automatic expect_acc(input int inst, input int master, input logic [15:0] addr,
                              input logic we, input logic [7:0] wdata, input int e, input bit completes);
        acc_t a;
        rdy_t r;
        a.inst = inst; a.addr = addr; a.we = we; a.wdata = wdata; a.cyc = e;
        aq.push_back(a);
        if (completes) begin
            if (!we) shadow[inst][master] = mem_val(addr);
            r.inst = inst; r.master = master; r.data = shadow[inst][master]; r.cyc = e + lat(inst);
            sbq.push_back(r);
        end
    endtask

    task automatic drive(input int inst, input int master, input logic req, input logic [15:0] addr,
                         input logic we, input logic [7:0] wdata);
        if (master == 0) begin
            c_req[inst] = req; c_address[inst] = addr; c_we[inst] = we; c_o_data[inst] = wdata;
        end else begin
            d_req[inst] = req; d_address[inst] = addr; d_we[inst] = we; d_o_data[inst] = wdata;
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) shadow[i][m] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_shadow();
    endtask

    task automatic wait_sb(input int n);
        int k = 0;
        do begin
            @(negedge clock); #1;
            k++;
        end while (sbq.size() > n && k < 200);
        chk("sb_timeout", 32'(sbq.size() > n), 0);
    endtask

    always @(negedge clock) begin
        rdy_t r;
        acc_t a;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (c_ready[i] || d_ready[i]) begin
                    chk("rdy_excl", 32'(c_ready[i] & d_ready[i]), 0);
                    if (sbq.size() == 0) begin
                        chk("unexp_ready", {c_ready[i], d_ready[i]}, 0);
                    end else begin
                        r = sbq.pop_front();
                        chk("rdy_inst", i, r.inst);
                        chk("rdy_master", 32'(d_ready[i]), r.master);
                        chk("rdy_cycle", cyc, r.cyc);
                        chk("rdy_data", d_ready[i] ? d_i_data[i] : c_i_data[i], r.data);
                    end
                end
                if (aq.size() != 0 && aq[0].cyc == cyc && aq[0].inst == i) begin
                    a = aq.pop_front();
                    chk("m_address", m_address[i], a.addr);
                    chk("m_we", 32'(m_we[i]), 32'(a.we));
                    if (a.we) chk("m_o_data", m_o_data[i], a.wdata);
                end else if (m_we[i]) begin
                    chk("unexp_we", 32'(m_we[i]), 0);
                end
            end
        end
    end

    initial begin
        int e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 0, 0, 16'h0, 0, 8'h0);
            drive(i, 1, 0, 16'h0, 0, 8'h0);
            d_lock[i] = 1'b0;
        end
        clear_shadow();
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_c_i_data", c_i_data[i], 0);
            chk("rst_d_i_data", d_i_data[i], 0);
            chk("rst_c_ready", 32'(c_ready[i]), 0);
            chk("rst_d_ready", 32'(d_ready[i]), 0);
            chk("rst_m_we", 32'(m_we[i]), 0);
            chk("rst_m_address", m_address[i], 0);
            chk("rst_m_o_data", m_o_data[i], 0);
        end
        reset = 1'b0;
        @(negedge clock);

        // core read, then core write leaving c_i_data at the read value
        drive(0, 0, 1, 16'h0100, 0, 8'h00);
        expect_acc(0, 0, 16'h0100, 0, 8'h00, cyc + 1, 1);
        wait_sb(0);
        drive(0, 0, 0, 16'h0100, 0, 8'h00);
        @(negedge clock);
        drive(0, 0, 1, 16'h0200, 1, 8'h3C);
        expect_acc(0, 0, 16'h0200, 1, 8'h3C, cyc + 1, 1);
        wait_sb(0);
        drive(0, 0, 0, 16'h0200, 0, 8'h00);

        // both masters requesting continuously from reset: core, secondary, core, secondary
        @(negedge clock);
        do_reset();
        drive(0, 0, 1, 16'h0310, 0, 8'h00);
        drive(0, 1, 1, 16'h0420, 0, 8'h00);
        e = cyc + 1;
        for (int k = 0; k < 4; k++)
            expect_acc(0, k % 2, (k % 2) ? 16'h0420 : 16'h0310, 0, 8'h00, e + 2 * k, 1);
        wait_sb(0);
        drive(0, 0, 0, 16'h0, 0, 8'h0);
        drive(0, 1, 0, 16'h0, 0, 8'h0);

        // LATENCY=3 secondary read; inputs change and request drops mid-access
        @(negedge clock);
        drive(1, 1, 1, 16'h0555, 0, 8'h00);
        expect_acc(1, 1, 16'h0555, 0, 8'h00, cyc + 1, 1);
        @(negedge clock); #1;
        drive(1, 1, 0, 16'h0999, 1, 8'hEE);
        wait_sb(0);

        // reset in the first cycle of a write drops m_we immediately
        @(negedge clock);
        drive(1, 1, 1, 16'h1234, 1, 8'h77);
        expect_acc(1, 1, 16'h1234, 1, 8'h77, cyc + 1, 0);
        @(negedge clock); #1;
        drive(1, 1, 0, 16'h0, 0, 8'h0);
        reset = 1'b1;
        #1;
        chk("abort_m_we", 32'(m_we[1]), 0);
        chk("abort_m_address", m_address[1], 0);
        chk("abort_m_o_data", m_o_data[1], 0);
        @(negedge clock);
        reset = 1'b0;
        clear_shadow();

        // reset in the second cycle of a read: no ready, outputs at reset values
        drive(1, 1, 1, 16'h2222, 0, 8'h00);
        expect_acc(1, 1, 16'h2222, 0, 8'h00, cyc + 1, 0);
        @(negedge clock);
        @(negedge clock); #1;
        drive(1, 1, 0, 16'h0, 0, 8'h0);
        reset = 1'b1;
        #1;
        chk("abort2_d_ready", 32'(d_ready[1]), 0);
        chk("abort2_d_i_data", d_i_data[1], 0);
        chk("abort2_m_address", m_address[1], 0);
        @(negedge clock);
        reset = 1'b0;
        clear_shadow();

        // first tie after reset goes to the core
        drive(1, 0, 1, 16'h0A0A, 0, 8'h00);
        drive(1, 1, 1, 16'h0B0B, 0, 8'h00);
        e = cyc + 1;
        expect_acc(1, 0, 16'h0A0A, 0, 8'h00, e, 1);
        expect_acc(1, 1, 16'h0B0B, 0, 8'h00, e + 4, 1);
        wait_sb(0);
        drive(1, 0, 0, 16'h0, 0, 8'h0);
        drive(1, 1, 0, 16'h0, 0, 8'h0);

`ifdef DMEM_ARBITER_BURST_LOCK_EN
        // d_lock keeps the secondary on ties; releasing it hands the next grant to the core
        @(negedge clock);
        do_reset();
        d_lock[0] = 1'b1;
        drive(0, 0, 1, 16'h0310, 0, 8'h00);
        drive(0, 1, 1, 16'h0420, 0, 8'h00);
        e = cyc + 1;
        for (int k = 0; k < 3; k++)
            expect_acc(0, 1, 16'h0420, 0, 8'h00, e + 2 * k, 1);
        expect_acc(0, 0, 16'h0310, 0, 8'h00, e + 6, 1);
        wait_sb(1);
        d_lock[0] = 1'b0;
        wait_sb(0);
        drive(0, 0, 0, 16'h0, 0, 8'h0);
        drive(0, 1, 0, 16'h0, 0, 8'h0);
`endif

        repeat (4) @(negedge clock);
        chk("sb_drained", sbq.size(), 0);
        chk("acc_drained", aq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, memory read latency in cycles from m_address valid to m_i_data valid; legal range 1..15.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req  input  1  core access request; held until c_ready.
REQ-005 c_address  input  16  core data address.
REQ-006 c_o_data  input  8  core write data.
REQ-007 c_we  input  1  core write (1) / read (0).
REQ-008 c_i_data  output  8  core read data, registered.
REQ-009 c_ready  output  1  one-cycle completion pulse to core.
REQ-010 d_req, d_address[16], d_o_data[8], d_we  inputs  secondary (DMA/loader) master, same meaning as the core inputs.
REQ-011 d_i_data  output  8 / d_ready  output  1  secondary master read data and completion pulse.
REQ-012 m_address  output  16 / m_o_data  output  8 / m_we  output  1  registered memory port.
REQ-013 m_i_data  input  8  memory read data.

Function
REQ-014 States: IDLE, ACCESS; 4-bit down-counter cnt; 1-bit last (last granted master).
REQ-015 IDLE, no request: all outputs hold, m_we 0.
REQ-016 IDLE, one request: grant it; latch its address/data/we into m_address/m_o_data/m_we; cnt <= LATENCY; go ACCESS.
REQ-017 IDLE, both requesting: grant the master not equal to last (round-robin).
REQ-018 m_we high for exactly the first ACCESS cycle; 0 otherwise.
REQ-019 ACCESS: cnt decrements each cycle; when cnt reaches 1, on the next edge capture m_i_data into granted *_i_data (reads only; writes leave *_i_data unchanged), pulse granted *_ready for one cycle, update last, return to IDLE.
REQ-020 Latency: request sampled at edge N -> ready high during cycle N+1+LATENCY; total LATENCY+1 cycles per access.
REQ-021 Back-to-back: a request held during the ready cycle is not re-accepted in that cycle; earliest re-grant is the edge ending the ready cycle (IDLE).
REQ-022 Only the granted master's ready may pulse; the other's ready stays 0.
REQ-023 Request inputs changing during ACCESS are ignored; latched values are used.
REQ-024 Request dropped mid-ACCESS: access still completes; ready still pulses.

Reset
REQ-025 On reset: state IDLE, cnt 0, last = secondary (core wins first tie), m_we 0, m_address 0, m_o_data 0, c_i_data 0, d_i_data 0, c_ready 0, d_ready 0.
REQ-026 Reset mid-ACCESS aborts the access immediately; no ready pulse; m_we deasserts asynchronously.

Configuration
REQ-027 Macro DMEM_ARBITER_BURST_LOCK_EN.
REQ-028 Defined: extra input d_lock (1 bit); in IDLE with both requesting, last = secondary and d_lock = 1, grant the secondary master again (burst).
REQ-029 Not defined: no d_lock port; pure round-robin per REQ-017.

Verification
REQ-030 LATENCY=1, core read 0x0100, memory returns 0xA5 -> m_address=0x0100, c_ready one cycle at N+2, c_i_data=0xA5, d_ready 0.
REQ-031 Core write 0x0200 <- 0x3C -> m_we high one cycle with m_o_data=0x3C, c_ready at N+2, c_i_data unchanged.
REQ-032 Both request continuously after reset -> grants alternate core, secondary, core, secondary; each ready one cycle.
REQ-033 LATENCY=3, secondary read -> d_ready at N+4; requests changed mid-access have no effect.
REQ-034 Reset asserted in second ACCESS cycle -> no ready pulse, all outputs at reset values, next core request granted first.
REQ-035 DMEM_ARBITER_BURST_LOCK_EN defined, d_lock=1, both requesting -> secondary granted on three consecutive accesses; d_lock=0 -> core next.
